aud_pwm_stream: RTL and testbench
=================================

AUD_PWM_STREAM -- requirements
Module: aud_pwm_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8: sample/duty width; PWM period = 2^DATA_WIDTH ticks.
REQ-002 Parameter FIFO_DEPTH, default 16: sample buffer entries; power of two, >= 2.
REQ-003 Parameter DIV_WIDTH, default 16: width of the tick divider input.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  play request; level-sensitive.
REQ-007 div  in  DIV_WIDTH  tick period = div+1 clk cycles.
REQ-008 s_valid  in  1  sample offered.
REQ-009 s_data  in  DATA_WIDTH  sample (unsigned duty).
REQ-010 s_ready  out  1  FIFO can accept; equals (level < FIFO_DEPTH).
REQ-011 underrun_clr  in  1  clears underrun flag.
REQ-012 aud_pwm  out  1  PWM audio output.
REQ-013 busy  out  1  high while state is PLAY.
REQ-014 underrun  out  1  sticky: a period started with FIFO empty.
REQ-015 level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Push occurs on a cycle with s_valid && s_ready; sample written, level +1.
REQ-017 Pop occurs only at a period start (REQ-021/REQ-023) with level > 0; head loaded into duty, level -1.
REQ-018 Push and pop in the same cycle leave level unchanged; a pushed sample is not poppable until the following cycle.
REQ-019 Prescaler presc counts clk cycles; tick asserts when presc >= div, presc then returns to 0; presc and tick run only in PLAY, presc held at 0 in IDLE; a div change takes effect immediately through this comparison.
REQ-020 States: IDLE, PLAY; no other states.
REQ-021 IDLE -> PLAY when enable && level > 0; in that cycle pop into duty, cnt <= 0, presc <= 0.
REQ-022 PLAY: on each tick cnt increments by 1 modulo 2^DATA_WIDTH.
REQ-023 PLAY, tick with cnt == 2^DATA_WIDTH-1 (period end): if !enable go IDLE; else if level > 0 pop into duty; else duty <= 2^(DATA_WIDTH-1) (midscale silence) and underrun <= 1.
REQ-024 enable deasserted mid-period: current period completes; stop only at period end.
REQ-025 aud_pwm = busy && (cnt < duty), decoded from registers only; duty 0 gives constant low; duty 2^DATA_WIDTH-1 gives low for 1 tick per period.
REQ-026 underrun_clr clears underrun; if a set condition coincides, set wins.
REQ-027 Playback continues after underrun; the next period end with level > 0 resumes normal pops.
REQ-028 No pushes are dropped: s_data is ignored only when s_ready is 0.

Reset
REQ-029 On resetn low, immediately: state IDLE, cnt 0, presc 0, duty 0, FIFO pointers 0, level 0, underrun 0; outputs aud_pwm 0, busy 0, s_ready 1.
REQ-030 Reset mid-operation discards all buffered samples and the current period; no partial period resumes after reset release.
REQ-031 First push is accepted on the first rising edge after resetn deasserts.

Verification
REQ-032 Reset: assert resetn=0 mid-playback -> aud_pwm 0, busy 0, level 0, s_ready 1, underrun 0, all without a clock edge.
REQ-033 Duty: div=0, push 8'h40, enable=1 -> busy rises next cycle; aud_pwm high for 64 clk then low for 192 clk; period 256 clk.
REQ-034 Underrun: div=0, push one sample 8'h10, enable=1 -> at clk 256 after start underrun=1, aud_pwm high 128 of each following 256 clk; underrun_clr pulse -> underrun 0, then re-set at the next period end.
REQ-035 Full: enable=0, push 17 samples back to back -> first 16 accepted, level 16, s_ready 0 while 17th held on s_valid; enable=1 -> 17th accepted on the cycle after the first pop.
REQ-036 Divider: div=3, push 8'h80, 8'hFF, enable=1 -> period 1024 clk; first period high 512 clk, second high 1020 clk.
REQ-037 Stop: deassert enable at cnt=100 of a period, two samples queued -> period finishes, busy falls at period end, level stays 2 (no further pop), aud_pwm 0 in IDLE.

Source files
------------

// File: rtl/aud_pwm_stream.sv
// Buffered PWM audio player: pushes fill a FIFO, and one sample is popped per 2^DATA_WIDTH-tick period.
// The output is decoded from registers with no pipeline latency. s_ready drops only while the FIFO is full.
module aud_pwm_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [DIV_WIDTH-1:0]        div,
  input  logic                        s_valid,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic                        s_ready,
  input  logic                        underrun_clr,
  output logic                        aud_pwm,
  output logic                        busy,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]         DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_PLAY} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  presc_q, presc_d;
  logic [DATA_WIDTH-1:0] duty_q, duty_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic tick;

  assign s_ready  = (level_q < DEPTH_L);
  assign push     = s_valid && s_ready;
  assign tick     = (state_q == ST_PLAY) && (presc_q >= div);
  assign busy     = (state_q == ST_PLAY);
  assign aud_pwm  = busy && (cnt_q < duty_q);
  assign underrun = underrun_q;
  assign level    = level_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    presc_d    = '0;
    duty_d     = duty_q;
    pop        = 1'b0;
    // A set on the same cycle as a clear wins because it is applied last.
    underrun_d = underrun_q && !underrun_clr;
    case (state_q)
      ST_IDLE: begin
        if (enable && (level_q != '0)) begin
          state_d = ST_PLAY;
          pop     = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_PLAY: begin
        presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
        if (tick) begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
          if (cnt_q == CNT_MAX) begin
            if (!enable) begin
              state_d = ST_IDLE;
            end else if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              duty_d     = MIDSCALE;
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) duty_d = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      presc_q    <= '0;
      duty_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      duty_q     <= duty_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage needs no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_aud_pwm_stream.sv
// Directed bench for aud_pwm_stream: a table of single-sample periods, plus reset, underrun, full and stop sequences.
module tb_aud_pwm_stream;
  logic        clk;
  logic        resetn;
  logic        enable;
  logic [15:0] div;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        underrun_clr;
  logic        aud_pwm;
  logic        busy;
  logic        underrun;
  logic [4:0]  level;

  int total;
  int bad;

  aud_pwm_stream #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .div          (div),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .underrun_clr (underrun_clr),
    .aud_pwm      (aud_pwm),
    .busy         (busy),
    .underrun     (underrun),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int div;
    int duty;
    int exp_high;
    int exp_period;
    int exp_high2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn       = 1'b0;
    enable       = 1'b0;
    div          = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    underrun_clr = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic push(input logic [7:0] v);
    s_valid = 1'b1;
    s_data  = v;
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(aud_pwm);
      step(1);
    end
  endtask

  initial begin
    int hi;
    int h0;
    total = 0;
    bad   = 0;

    //           div  duty  high  period high2
    vecs[0] = '{0, 8'h40,   64,  256, 128};
    vecs[1] = '{0, 8'h00,    0,  256, 128};
    vecs[2] = '{0, 8'hFF,  255,  256, 128};
    vecs[3] = '{1, 8'h80,  256,  512, 256};
    vecs[4] = '{3, 8'h80,  512, 1024, 512};
    vecs[5] = '{3, 8'hFF, 1020, 1024, 512};
    vecs[6] = '{2, 8'h01,    3,  768, 384};

    resetn       = 1'b0;
    enable       = 1'b0;
    div          = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    underrun_clr = 1'b0;
    #1;
    chk("rst_aud_pwm", int'(aud_pwm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_underrun", int'(underrun), 0);

    foreach (vecs[i]) begin
      do_reset();
      div = 16'(vecs[i].div);
      push(8'(vecs[i].duty));
      chk($sformatf("v%0d_level", i), int'(level), 1);
      enable = 1'b1;
      step(1);
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      hi = 0;
      for (int k = 0; k < vecs[i].exp_period; k++) begin
        hi += int'(aud_pwm);
        if (k == vecs[i].exp_period - 1)
          chk($sformatf("v%0d_underrun_before_end", i), int'(underrun), 0);
        step(1);
      end
      chk($sformatf("v%0d_high", i), hi, vecs[i].exp_high);
      chk($sformatf("v%0d_underrun_at_end", i), int'(underrun), 1);
      count_high(vecs[i].exp_period, hi);
      chk($sformatf("v%0d_midscale_high", i), hi, vecs[i].exp_high2);
    end

    // Underrun clear, set-wins-over-clear, and resumption of pops.
    do_reset();
    push(8'h10);
    enable = 1'b1;
    step(1);
    step(256);
    chk("ur_set", int'(underrun), 1);
    step(44);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    chk("ur_cleared", int'(underrun), 0);
    step(210);
    chk("ur_still_clear", int'(underrun), 0);
    step(1);
    chk("ur_reset_at_end", int'(underrun), 1);
    step(255);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    chk("ur_set_wins", int'(underrun), 1);
    push(8'h20);
    chk("ur_level_refill", int'(level), 1);
    step(255);
    count_high(256, hi);
    chk("ur_resume_high", hi, 32);
    chk("ur_resume_level", int'(level), 0);

    // Asynchronous reset in mid-playback with samples queued.
    push(8'h50);
    push(8'h60);
    push(8'h70);
    chk("ar_level_pre", int'(level), 3);
    chk("ar_aud_pwm_pre", int'(aud_pwm), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_aud_pwm", int'(aud_pwm), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_level", int'(level), 0);
    chk("ar_s_ready", int'(s_ready), 1);
    chk("ar_underrun", int'(underrun), 0);
    enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    push(8'h33);
    chk("ar_first_push", int'(level), 1);
    step(3);
    chk("ar_no_resume", int'(busy), 0);

    // Full FIFO: 17th sample held until the first pop frees a slot.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + 1);
      step(1);
    end
    s_data = 8'hAA;
    step(3);
    chk("full_level", int'(level), 16);
    chk("full_s_ready", int'(s_ready), 0);
    enable = 1'b1;
    step(1);
    chk("full_busy", int'(busy), 1);
    chk("full_level_after_pop", int'(level), 15);
    h0 = int'(aud_pwm);
    step(1);
    s_valid = 1'b0;
    chk("full_17th_accepted", int'(level), 16);
    count_high(255, hi);
    chk("full_first_high", hi + h0, 1);
    count_high(256, hi);
    chk("full_second_high", hi, 2);

    // Stop mid-period: finish the period, then idle without popping.
    do_reset();
    push(8'h40);
    push(8'h41);
    push(8'h42);
    enable = 1'b1;
    step(1);
    chk("stop_level_run", int'(level), 2);
    step(100);
    enable = 1'b0;
    step(155);
    chk("stop_busy_last", int'(busy), 1);
    step(1);
    chk("stop_busy_fall", int'(busy), 0);
    chk("stop_level", int'(level), 2);
    step(10);
    chk("stop_idle_pwm", int'(aud_pwm), 0);
    chk("stop_idle_level", int'(level), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
